// File: rtl/anim_blit_if.sv
// Job bus between the animation sequencer and the sprite blitter.
// The master raises blit_req with a stable job description; the slave answers with a one-cycle blit_done.
interface anim_blit_if #(
  parameter int ADDR_W = 16
);
  logic              blit_req;
  logic              blit_erase;
  logic [8:0]        blit_x;
  logic [7:0]        blit_y;
  logic [ADDR_W-1:0] blit_base;
  logic              blit_done;

  modport master (
    output blit_req,
    output blit_erase,
    output blit_x,
    output blit_y,
    output blit_base,
    input  blit_done
  );

  modport slave (
    input  blit_req,
    input  blit_erase,
    input  blit_x,
    input  blit_y,
    input  blit_base,
    output blit_done
  );
endinterface

// File: rtl/anim_sequencer.sv
// Paces a bouncing, frame-cycling sprite off a free-running tick and issues
// an erase-then-draw pair of blitter jobs for every animation step.
module anim_sequencer #(
  parameter int TICK_DIV    = 5_000_000,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_WORDS = 9600,
  parameter int ADDR_W      = 16,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 240,
  parameter int X_STEP      = 4,
  parameter int Y_POS       = 70
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  anim_blit_if.master       blit,
  output logic              o_busy,
  output logic [1:0]        o_frame_idx,
  output logic              o_overrun
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_DRAW,
    S_ADVANCE
  } state_t;

  state_t            r_state;
  logic              r_dir;
  logic [9:0]        r_x;
  logic [1:0]        r_frame;
  logic [CNT_W-1:0]  r_count;
  logic              r_pending;
  logic              r_overrun;
  logic              r_busy;
  logic              r_req;
  logic              r_erase;
  logic [8:0]        r_bx;
  logic [ADDR_W-1:0] r_base;

  logic              w_tick;
  logic [9:0]        w_x_inc;
  logic [9:0]        w_x_dec;
  logic [9:0]        w_x_next;
  logic              w_dir_next;
  logic [1:0]        w_frame_next;
  logic [ADDR_W-1:0] w_base;

  assign w_tick       = (r_state != S_IDLE) && (r_count == CNT_W'(TICK_DIV - 1));
  assign w_x_inc      = r_x + 10'(X_STEP);
  assign w_x_dec      = r_x - 10'(X_STEP);
  assign w_frame_next = (r_frame == 2'(NUM_FRAMES - 1)) ? 2'd0 : r_frame + 2'd1;
  assign w_base       = ADDR_W'(int'(r_frame) * FRAME_WORDS);

  // r_dir: 0 = moving right, 1 = moving left; the limit test uses 10 bits so it cannot wrap.
  always_comb begin
    w_x_next   = w_x_inc;
    w_dir_next = r_dir;
    if (!r_dir) begin
      if (w_x_inc > 10'(X_MAX)) begin
        w_dir_next = 1'b1;
        w_x_next   = w_x_dec;
      end
    end else if (r_x < 10'(X_MIN + X_STEP)) begin
      w_dir_next = 1'b0;
      w_x_next   = w_x_inc;
    end else begin
      w_x_next   = w_x_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dir     <= 1'b0;
      r_x       <= 10'(X_MIN);
      r_frame   <= 2'd0;
      r_count   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
      r_req     <= 1'b0;
      r_erase   <= 1'b0;
      r_bx      <= 9'(X_MIN);
      r_base    <= '0;
    end else begin
      // WAIT hands the pending tick to the step; a tick landing in that same cycle stays pending.
      if (r_state != S_IDLE) begin
        r_count <= w_tick ? '0 : r_count + 1'b1;
        if (r_state == S_WAIT) begin
          r_pending <= r_pending & w_tick;
        end else if (w_tick) begin
          r_pending <= 1'b1;
          if (r_pending) r_overrun <= 1'b1;
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_DRAW;
            r_busy    <= 1'b1;
            r_dir     <= 1'b0;
            r_x       <= 10'(X_MIN);
            r_frame   <= 2'd0;
            r_count   <= '0;
            r_pending <= 1'b0;
            r_req     <= 1'b1;
            r_erase   <= 1'b0;
            r_bx      <= 9'(X_MIN);
            r_base    <= '0;
          end
        end
        S_WAIT: begin
          if (r_pending || w_tick) begin
            r_state <= S_ERASE;
            r_req   <= 1'b1;
            r_erase <= 1'b1;
            r_bx    <= r_x[8:0];
          end
        end
        S_ERASE: begin
          if (blit.blit_done) begin
            r_req   <= 1'b0;
            r_x     <= w_x_next;
            r_dir   <= w_dir_next;
            r_frame <= w_frame_next;
            r_state <= S_DRAW;
          end
        end
        // Entered from ERASE with req low, which guarantees the idle cycle between jobs.
        S_DRAW: begin
          if (!r_req) begin
            r_req   <= 1'b1;
            r_erase <= 1'b0;
            r_bx    <= r_x[8:0];
            r_base  <= w_base;
          end else if (blit.blit_done) begin
            r_req   <= 1'b0;
            r_state <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign blit.blit_req   = r_req;
  assign blit.blit_erase = r_erase;
  assign blit.blit_x     = r_bx;
  assign blit.blit_y     = 8'(Y_POS);
  assign blit.blit_base  = r_base;
  assign o_busy          = r_busy;
  assign o_frame_idx     = r_frame;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer: a blitter model pops expected jobs from a queue on every
// request edge and acknowledges after the latency stored with that job.
module tb_anim_sequencer;

  localparam int TICK = 16;
  localparam int FW   = 9600;

  typedef struct {
    int lat;
    bit erase;
    int x;
    int base;
    int frame;
  } job_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic stop;
  logic busy;
  logic [1:0] frameIdx;
  logic overrun;

  anim_blit_if #(.ADDR_W(16)) blitBus ();

  anim_sequencer #(
    .TICK_DIV(TICK),
    .NUM_FRAMES(4),
    .FRAME_WORDS(FW),
    .ADDR_W(16),
    .X_MIN(0),
    .X_MAX(240),
    .X_STEP(4),
    .Y_POS(70)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_start(start),
    .i_stop(stop),
    .blit(blitBus),
    .o_busy(busy),
    .o_frame_idx(frameIdx),
    .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  job_t expQ[$];
  job_t table2[9];
  int   compared = 0;
  int   mismatched = 0;
  int   doneCount = 0;
  int   mX;
  bit   mDir;
  int   mFrame;

  job_t curJob;
  int   ackCnt;
  bit   active;
  bit   prevReq;
  int   capX;
  bit   capErase;
  int   capBase;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic startV, input logic stopV, input logic resetV, input int cycles);
    start = startV;
    stop  = stopV;
    reset = resetV;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic void pushJob(input int lat, input bit er, input int x, input int base, input int fr);
    job_t j;
    j.lat = lat; j.erase = er; j.x = x; j.base = base; j.frame = fr;
    expQ.push_back(j);
  endfunction

  // Reference step: erase at the old position, bounce-aware move, frame advance, draw.
  function automatic void pushStep(input int latE, input int latD);
    pushJob(latE, 1'b1, mX, 0, mFrame);
    if (!mDir) begin
      if (mX + 4 > 240) begin mDir = 1'b1; mX = mX - 4; end
      else mX = mX + 4;
    end else begin
      if (mX < 4) begin mDir = 1'b0; mX = mX + 4; end
      else mX = mX - 4;
    end
    mFrame = (mFrame + 1) % 4;
    pushJob(latD, 1'b0, mX, mFrame * FW, mFrame);
  endfunction

  task automatic waitIdleQueue(input string name, input int bound);
    int n = 0;
    while (!(expQ.size() == 0 && blitBus.blit_req == 1'b0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, n < bound, 1);
  endtask

  task automatic waitEraseReq(input int bound);
    int n = 0;
    while (!(blitBus.blit_req && blitBus.blit_erase) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("erase_req_seen", n < bound, 1);
  endtask

  task automatic waitNotBusy(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("returned_idle", n < bound, 1);
  endtask

  task automatic waitDoneCount(input int target, input int bound);
    int n = 0;
    while (doneCount < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("slow_pair_done", n < bound, 1);
  endtask

  // Blitter model: pops and checks a job on each req rising edge, acks after its latency.
  initial begin
    blitBus.blit_done = 1'b0;
    active  = 1'b0;
    prevReq = 1'b0;
    ackCnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        active            = 1'b0;
        prevReq           = 1'b0;
        blitBus.blit_done = 1'b0;
      end else begin
        blitBus.blit_done = 1'b0;
        if (active) begin
          ackCnt++;
          if (ackCnt >= curJob.lat) begin
            blitBus.blit_done = 1'b1;
            active = 1'b0;
            doneCount++;
            checkOutput("job_stable", (blitBus.blit_x == capX) && (blitBus.blit_erase == capErase) &&
                        (capErase || blitBus.blit_base == capBase), 1);
          end
        end else if (blitBus.blit_req && !prevReq) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_job", 1, 0);
            curJob.lat = 3;
          end else begin
            curJob = expQ.pop_front();
            checkOutput("job_erase", blitBus.blit_erase, curJob.erase);
            checkOutput("job_x", blitBus.blit_x, curJob.x);
            checkOutput("job_y", blitBus.blit_y, 70);
            checkOutput("job_frame", frameIdx, curJob.frame);
            if (!curJob.erase) checkOutput("job_base", blitBus.blit_base, curJob.base);
          end
          capX     = blitBus.blit_x;
          capErase = blitBus.blit_erase;
          capBase  = blitBus.blit_base;
          ackCnt   = 0;
          active   = 1'b1;
        end
        prevReq = blitBus.blit_req;
      end
    end
  end

  initial begin
    int n;
    int base;
    table2 = '{'{3, 1'b0, 0, 0, 0},      '{3, 1'b1, 0, 0, 0},
               '{3, 1'b0, 4, 9600, 1},   '{3, 1'b1, 4, 0, 1},
               '{3, 1'b0, 8, 19200, 2},  '{3, 1'b1, 8, 0, 2},
               '{3, 1'b0, 12, 28800, 3}, '{3, 1'b1, 12, 0, 3},
               '{3, 1'b0, 16, 0, 0}};

    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    checkOutput("rst_req", blitBus.blit_req, 0);
    checkOutput("rst_erase", blitBus.blit_erase, 0);
    checkOutput("rst_x", blitBus.blit_x, 0);
    checkOutput("rst_y", blitBus.blit_y, 70);
    checkOutput("rst_base", blitBus.blit_base, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame", frameIdx, 0);
    checkOutput("rst_overrun", overrun, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);

    $display("[TB] first draw and three steps");
    for (int i = 0; i < 9; i++) expQ.push_back(table2[i]);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_req", blitBus.blit_req, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    waitIdleQueue("steps_done", 400);
    checkOutput("frame_wrapped", frameIdx, 0);
    checkOutput("no_overrun_steps", overrun, 0);

    $display("[TB] bounce at X_MAX and X_MIN, start ignored while busy");
    mX = 16; mDir = 1'b0; mFrame = 0;
    for (int i = 0; i < 117; i++) pushStep(3, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    waitIdleQueue("bounce_done", 3000);
    checkOutput("bounce_frame", frameIdx, mFrame);
    checkOutput("bounce_last_x", blitBus.blit_x, 4);
    checkOutput("no_overrun_bounce", overrun, 0);

    $display("[TB] stop during erase");
    pushStep(3, 3);
    waitEraseReq(60);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    waitNotBusy(60);
    checkOutput("stop_pair_done", expQ.size(), 0);
    checkOutput("stop_req", blitBus.blit_req, 0);
    checkOutput("stop_frame", frameIdx, mFrame);
    checkOutput("stop_x", blitBus.blit_x, mX);
    applyStimulus(1'b0, 1'b0, 1'b0, 40);
    checkOutput("stays_idle", busy, 0);

    $display("[TB] slow blitter: pending tick and overrun");
    mX = 0; mDir = 1'b0; mFrame = 0;
    pushJob(3, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    waitIdleQueue("restart_done", 100);
    checkOutput("restart_overrun", overrun, 0);
    pushStep(20, 20);
    pushStep(20, 3);
    pushStep(3, 3);
    base = doneCount;
    waitDoneCount(base + 2, 200);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!blitBus.blit_req && n < 40);
    checkOutput("pending_gap", n, 3);
    checkOutput("overrun_set", overrun, 1);

    $display("[TB] reset during a job");
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    checkOutput("pre_reset_req", blitBus.blit_req, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("mid_rst_req", blitBus.blit_req, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_x", blitBus.blit_x, 0);
    checkOutput("mid_rst_frame", frameIdx, 0);
    checkOutput("mid_rst_overrun", overrun, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    expQ.delete();
    applyStimulus(1'b0, 1'b0, 1'b0, 20);
    checkOutput("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
